// File: rtl/cpu_datamem_arb_if.sv
// Request/grant/read-return bundle for the two-port CPU data memory.
// The slave side is the memory; the master side drives both requesting ports.
interface cpu_datamem_arb_if #(
  parameter int ADDR_W   = 16,
  parameter int WR_BYTES = 4,
  parameter int RD_BYTES = 64
);
  logic                    init_busy;
  logic                    contention;

  logic                    a_req;
  logic                    a_we;
  logic [ADDR_W-1:0]       a_addr;
  logic [8*WR_BYTES-1:0]   a_wdata;
  logic [WR_BYTES-1:0]     a_be;
  logic                    a_gnt;
  logic                    a_rvalid;
  logic [8*WR_BYTES-1:0]   a_rdata;

  logic                    b_req;
  logic                    b_we;
  logic [ADDR_W-1:0]       b_addr;
  logic [8*WR_BYTES-1:0]   b_wdata;
  logic [WR_BYTES-1:0]     b_be;
  logic                    b_gnt;
  logic                    b_rvalid;
  logic [8*RD_BYTES-1:0]   b_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_be,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output init_busy, contention
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_be,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  init_busy, contention
  );
endinterface

// File: rtl/cpu_datamem_arb.sv
// Byte-addressable dual-port data memory: narrow CPU port A, accelerator port B
// with wide reads, one access per cycle via fixed or round-robin arbitration.
module cpu_datamem_arb #(
  parameter int ADDR_W   = 16,
  parameter int WR_BYTES = 4,
  parameter int RD_BYTES = 64,
  parameter int ARB_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_datamem_arb_if.slave  bus
);

  localparam int MEM_BYTES = 2 ** ADDR_W;
  localparam int CLR_N     = MEM_BYTES / RD_BYTES;
  localparam int PTR_W     = (CLR_N > 1) ? $clog2(CLR_N) : 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    clr_en;
  logic [ADDR_W-1:0]       clr_base;

  logic [7:0]              mem_q [MEM_BYTES];

  logic                    run;
  logic                    both_req;
  logic                    a_gnt, b_gnt;
  logic                    last_a_q;
  logic                    contention_q;

  logic                    w_en;
  logic [ADDR_W-1:0]       w_addr;
  logic [8*WR_BYTES-1:0]   w_data;
  logic [WR_BYTES-1:0]     w_be;

  logic [8*WR_BYTES-1:0]   a_rd_word;
  logic [8*RD_BYTES-1:0]   b_rd_word;
  logic                    a_rvalid_q, b_rvalid_q;
  logic [8*WR_BYTES-1:0]   a_rdata_q;
  logic [8*RD_BYTES-1:0]   b_rdata_q;

  // Address arithmetic is modulo the array size, so every access wraps at the top.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input int off);
    return base + ADDR_W'(off);
  endfunction

  // ---------------- clear sequencer ----------------
  assign clr_base = ADDR_W'(32'(ptr_q) * 32'(RD_BYTES));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_en = 1'b1;
        if (ptr_q == PTR_W'(CLR_N - 1)) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------- arbiter ----------------
  assign run      = (state_q == S_RUN) && !rst;
  assign both_req = bus.a_req & bus.b_req;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (run) begin
      if (both_req) begin
        if (ARB_MODE == 0) begin
          a_gnt = 1'b1;
        end else if (last_a_q) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  // last_a_q == 0 means B was granted last, so A wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_a_q     <= 1'b0;
      contention_q <= 1'b0;
    end else begin
      if (a_gnt || b_gnt) begin
        last_a_q <= a_gnt;
      end
      contention_q <= run & both_req;
    end
  end

  // ---------------- write path ----------------
  always_comb begin
    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_be   = '0;
    if (a_gnt) begin
      w_en   = bus.a_we;
      w_addr = bus.a_addr;
      w_data = bus.a_wdata;
      w_be   = bus.a_be;
    end else if (b_gnt) begin
      w_en   = bus.b_we;
      w_addr = bus.b_addr;
      w_data = bus.b_wdata;
      w_be   = bus.b_be;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < RD_BYTES; i++) begin
        mem_q[wrap_add(clr_base, i)] <= 8'h00;
      end
    end else if (w_en) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        if (w_be[i]) begin
          mem_q[wrap_add(w_addr, i)] <= w_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    a_rd_word = '0;
    for (int i = 0; i < WR_BYTES; i++) begin
      a_rd_word[8*i +: 8] = mem_q[wrap_add(bus.a_addr, i)];
    end
  end

  always_comb begin
    b_rd_word = '0;
    for (int i = 0; i < RD_BYTES; i++) begin
      b_rd_word[8*i +: 8] = mem_q[wrap_add(bus.b_addr, i)];
    end
  end

  // Reads sample the array at the grant edge; reads and writes never share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_gnt & ~bus.a_we;
      b_rvalid_q <= b_gnt & ~bus.b_we;
      if (a_gnt && !bus.a_we) begin
        a_rdata_q <= a_rd_word;
      end
      if (b_gnt && !bus.b_we) begin
        b_rdata_q <= b_rd_word;
      end
    end
  end

  assign bus.init_busy  = (state_q == S_INIT) | rst;
  assign bus.contention = contention_q;
  assign bus.a_gnt      = a_gnt;
  assign bus.b_gnt      = b_gnt;
  assign bus.a_rvalid   = a_rvalid_q;
  assign bus.b_rvalid   = b_rvalid_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_cpu_datamem_arb.sv
// Directed bench for cpu_datamem_arb: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_cpu_datamem_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpu_datamem_arb_if #(.ADDR_W(16), .WR_BYTES(4), .RD_BYTES(64)) bus_rr ();
  cpu_datamem_arb_if #(.ADDR_W(16), .WR_BYTES(4), .RD_BYTES(64)) bus_fp ();

  cpu_datamem_arb #(.ADDR_W(16), .WR_BYTES(4), .RD_BYTES(64), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr)
  );

  cpu_datamem_arb #(.ADDR_W(16), .WR_BYTES(4), .RD_BYTES(64), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus_rr.a_req = 1'b0; bus_rr.a_we = 1'b0; bus_rr.a_addr = '0; bus_rr.a_wdata = '0; bus_rr.a_be = '0;
    bus_rr.b_req = 1'b0; bus_rr.b_we = 1'b0; bus_rr.b_addr = '0; bus_rr.b_wdata = '0; bus_rr.b_be = '0;
    bus_fp.a_req = 1'b0; bus_fp.a_we = 1'b0; bus_fp.a_addr = '0; bus_fp.a_wdata = '0; bus_fp.a_be = '0;
    bus_fp.b_req = 1'b0; bus_fp.b_we = 1'b0; bus_fp.b_addr = '0; bus_fp.b_wdata = '0; bus_fp.b_be = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_all();
    repeat (3) tick();
    bus_rr.a_req = 1'b1;
    #1;
    n_checks++;
    if (bus_rr.init_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_init_busy: got %b expected 1", bus_rr.init_busy);
    end
    n_checks++;
    if (bus_rr.a_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_a_gnt: got %b expected 0", bus_rr.a_gnt);
    end
    n_checks++;
    if ({bus_rr.a_rvalid, bus_rr.b_rvalid, bus_rr.contention} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000",
                         {bus_rr.a_rvalid, bus_rr.b_rvalid, bus_rr.contention});
    end
    n_checks++;
    if (bus_rr.a_rdata !== 32'h0 || bus_rr.b_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got a=%h expected all zero", bus_rr.a_rdata);
    end
  endtask

  task automatic test_init;
    int  n;
    logic gnt_seen;
    n = 0;
    gnt_seen = 1'b0;
    rst = 1'b0;
    while (bus_rr.init_busy === 1'b1 && n < 4000) begin
      if (bus_rr.a_gnt !== 1'b0) gnt_seen = 1'b1;
      tick();
      n++;
    end
    bus_rr.a_req = 1'b0;
    n_checks++;
    if (n !== 1024) begin
      n_fail++; $display("FAIL init_length: got %0d cycles expected 1024", n);
    end
    n_checks++;
    if (gnt_seen !== 1'b0) begin
      n_fail++; $display("FAIL init_no_grant: got gnt_seen=%b expected 0", gnt_seen);
    end
    n_checks++;
    if (bus_fp.init_busy !== 1'b0) begin
      n_fail++; $display("FAIL init_fp_done: got %b expected 0", bus_fp.init_busy);
    end
    bus_rr.b_req = 1'b1; bus_rr.b_we = 1'b0; bus_rr.b_addr = 16'hFFC0;
    #1;
    n_checks++;
    if (bus_rr.b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL init_first_gnt: got %b expected 1", bus_rr.b_gnt);
    end
    tick();
    bus_rr.b_req = 1'b0;
    n_checks++;
    if (bus_rr.b_rvalid !== 1'b1 || bus_rr.b_rdata !== '0) begin
      n_fail++; $display("FAIL init_cleared_read: got rvalid=%b rdata=%h expected 1 and zero",
                         bus_rr.b_rvalid, bus_rr.b_rdata);
    end
  endtask

  task automatic test_byte_enable;
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b1; bus_rr.a_addr = 16'h1000;
    bus_rr.a_wdata = 32'h11223344; bus_rr.a_be = 4'b0101;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL be_write_gnt: got %b expected 1", bus_rr.a_gnt);
    end
    tick();
    bus_rr.a_we = 1'b0;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1 || bus_rr.a_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL be_read_gnt: got gnt=%b rvalid=%b expected 1 0", bus_rr.a_gnt, bus_rr.a_rvalid);
    end
    tick();
    bus_rr.a_req = 1'b0;
    n_checks++;
    if (bus_rr.a_rvalid !== 1'b1 || bus_rr.a_rdata !== 32'h00220044) begin
      n_fail++; $display("FAIL be_readback: got rvalid=%b rdata=%h expected 1 00220044",
                         bus_rr.a_rvalid, bus_rr.a_rdata);
    end
    tick();
    n_checks++;
    if (bus_rr.a_rvalid !== 1'b0 || bus_rr.a_rdata !== 32'h00220044) begin
      n_fail++; $display("FAIL be_hold: got rvalid=%b rdata=%h expected 0 00220044",
                         bus_rr.a_rvalid, bus_rr.a_rdata);
    end
  endtask

  task automatic test_be_zero;
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b1; bus_rr.a_addr = 16'h1000;
    bus_rr.a_wdata = 32'hFFFFFFFF; bus_rr.a_be = 4'b0000;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL be0_gnt: got %b expected 1", bus_rr.a_gnt);
    end
    tick();
    bus_rr.a_we = 1'b0;
    tick();
    bus_rr.a_req = 1'b0;
    n_checks++;
    if (bus_rr.a_rdata !== 32'h00220044) begin
      n_fail++; $display("FAIL be0_nochange: got %h expected 00220044", bus_rr.a_rdata);
    end
  endtask

  task automatic test_wrap;
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b1; bus_rr.a_addr = 16'hFFFE;
    bus_rr.a_wdata = 32'hDEADBEEF; bus_rr.a_be = 4'b1111;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wrap_write_gnt: got %b expected 1", bus_rr.a_gnt);
    end
    tick();
    bus_rr.a_req = 1'b0;
    bus_rr.b_req = 1'b1; bus_rr.b_we = 1'b0; bus_rr.b_addr = 16'hFFFE;
    #1;
    n_checks++;
    if (bus_rr.b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wrap_read_gnt: got %b expected 1", bus_rr.b_gnt);
    end
    tick();
    bus_rr.b_req = 1'b0;
    n_checks++;
    if (bus_rr.b_rdata[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wrap_b_low: got %h expected DEADBEEF", bus_rr.b_rdata[31:0]);
    end
    n_checks++;
    if (bus_rr.b_rdata[511:32] !== '0) begin
      n_fail++; $display("FAIL wrap_b_upper: got %h expected zero", bus_rr.b_rdata[511:32]);
    end
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b0; bus_rr.a_addr = 16'h0000;
    tick();
    bus_rr.a_req = 1'b0;
    n_checks++;
    if (bus_rr.a_rdata !== 32'h0000DEAD) begin
      n_fail++; $display("FAIL wrap_low_bytes: got %h expected 0000DEAD", bus_rr.a_rdata);
    end
  endtask

  task automatic test_arb_rr;
    logic exp_a;
    bus_rr.b_req = 1'b1; bus_rr.b_we = 1'b0; bus_rr.b_addr = 16'h1000;
    #1;
    n_checks++;
    if (bus_rr.b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rr_single_b: got %b expected 1", bus_rr.b_gnt);
    end
    tick();
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b0; bus_rr.a_addr = 16'h1000;
    bus_rr.b_addr = 16'hFFFE;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      #1;
      n_checks++;
      if (bus_rr.a_gnt !== exp_a || bus_rr.b_gnt !== !exp_a) begin
        n_fail++; $display("FAIL rr_grant_%0d: got a=%b b=%b expected a=%b b=%b",
                           k, bus_rr.a_gnt, bus_rr.b_gnt, exp_a, !exp_a);
      end
      tick();
      n_checks++;
      if (bus_rr.contention !== 1'b1) begin
        n_fail++; $display("FAIL rr_contention_%0d: got %b expected 1", k, bus_rr.contention);
      end
      if (exp_a) begin
        n_checks++;
        if (bus_rr.a_rvalid !== 1'b1 || bus_rr.a_rdata !== 32'h00220044) begin
          n_fail++; $display("FAIL rr_a_data_%0d: got rvalid=%b rdata=%h expected 1 00220044",
                             k, bus_rr.a_rvalid, bus_rr.a_rdata);
        end
      end else begin
        n_checks++;
        if (bus_rr.b_rvalid !== 1'b1 || bus_rr.b_rdata[31:0] !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rr_b_data_%0d: got rvalid=%b rdata=%h expected 1 DEADBEEF",
                             k, bus_rr.b_rvalid, bus_rr.b_rdata[31:0]);
        end
      end
    end
    bus_rr.a_req = 1'b0;
    bus_rr.b_req = 1'b0;
    tick();
    n_checks++;
    if (bus_rr.contention !== 1'b0) begin
      n_fail++; $display("FAIL rr_contention_end: got %b expected 0", bus_rr.contention);
    end
  endtask

  task automatic test_arb_fixed;
    bus_fp.a_req = 1'b1; bus_fp.a_we = 1'b0; bus_fp.a_addr = 16'h2000;
    bus_fp.b_req = 1'b1; bus_fp.b_we = 1'b0; bus_fp.b_addr = 16'h3000;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (bus_fp.a_gnt !== 1'b1 || bus_fp.b_gnt !== 1'b0) begin
        n_fail++; $display("FAIL fp_grant_%0d: got a=%b b=%b expected a=1 b=0",
                           k, bus_fp.a_gnt, bus_fp.b_gnt);
      end
      tick();
      n_checks++;
      if (bus_fp.contention !== 1'b1 || bus_fp.b_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL fp_after_%0d: got contention=%b b_rvalid=%b expected 1 0",
                           k, bus_fp.contention, bus_fp.b_rvalid);
      end
    end
    bus_fp.a_req = 1'b0;
    bus_fp.b_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b1; bus_rr.a_addr = 16'h5000;
    bus_rr.a_wdata = 32'hCAFEF00D; bus_rr.a_be = 4'b1111;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL b2b_write_gnt: got %b expected 1", bus_rr.a_gnt);
    end
    tick();
    bus_rr.a_req = 1'b0;
    bus_rr.b_req = 1'b1; bus_rr.b_we = 1'b0; bus_rr.b_addr = 16'h5000;
    #1;
    n_checks++;
    if (bus_rr.b_gnt !== 1'b1 || bus_rr.b_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_read_gnt: got gnt=%b rvalid=%b expected 1 0", bus_rr.b_gnt, bus_rr.b_rvalid);
    end
    tick();
    bus_rr.b_req = 1'b0;
    n_checks++;
    if (bus_rr.b_rvalid !== 1'b1 || bus_rr.b_rdata[31:0] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL b2b_data: got rvalid=%b rdata=%h expected 1 CAFEF00D",
                         bus_rr.b_rvalid, bus_rr.b_rdata[31:0]);
    end
  endtask

  task automatic test_reset_mid_init;
    int n;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus_rr.b_rdata !== '0 || bus_rr.b_rvalid !== 1'b0 || bus_rr.init_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst2_state: got b_rdata_low=%h rvalid=%b busy=%b expected 0 0 1",
                         bus_rr.b_rdata[31:0], bus_rr.b_rvalid, bus_rr.init_busy);
    end
    rst = 1'b0;
    repeat (500) tick();
    n_checks++;
    if (bus_rr.init_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst2_busy_500: got %b expected 1", bus_rr.init_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (bus_rr.init_busy === 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 1024) begin
      n_fail++; $display("FAIL rst2_init_length: got %0d cycles expected 1024", n);
    end
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b0; bus_rr.a_addr = 16'h1000;
    bus_rr.b_req = 1'b1; bus_rr.b_we = 1'b0; bus_rr.b_addr = 16'hFFFE;
    #1;
    n_checks++;
    if (bus_rr.a_gnt !== 1'b1 || bus_rr.b_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst2_first_contention: got a=%b b=%b expected a=1 b=0",
                         bus_rr.a_gnt, bus_rr.b_gnt);
    end
    tick();
    n_checks++;
    if (bus_rr.a_rvalid !== 1'b1 || bus_rr.a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst2_a_cleared: got rvalid=%b rdata=%h expected 1 0",
                         bus_rr.a_rvalid, bus_rr.a_rdata);
    end
    n_checks++;
    if (bus_rr.b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst2_second_contention: got b=%b expected 1", bus_rr.b_gnt);
    end
    tick();
    bus_rr.a_req = 1'b0;
    bus_rr.b_req = 1'b0;
    n_checks++;
    if (bus_rr.b_rvalid !== 1'b1 || bus_rr.b_rdata[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL rst2_b_cleared: got rvalid=%b rdata=%h expected 1 0",
                         bus_rr.b_rvalid, bus_rr.b_rdata[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte_enable();
    test_be_zero();
    test_wrap();
    test_arb_rr();
    test_arb_fixed();
    test_back_to_back();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
